// File: rtl/usb_cmd_dispatch.sv
// Host command sequencer: synchronises USB command strobes into i_clk_sys, executes
// register/acquisition commands and returns a held finish level with a response code.
module usb_cmd_dispatch #(
    parameter int unsigned NREG     = 8,
    parameter int unsigned FIN_HOLD = 8
) (
    input  logic                 i_clk_sys,
    input  logic                 i_rst_n,
    input  logic                 i_cmd_come,
    input  logic [15:0]          i_cmd,
    input  logic [31:0]          i_cmd_param,
    output logic                 o_cmd_finish,
    output logic [15:0]          o_cmd_finish_code,
    output logic [NREG*16-1:0]   o_regs,
    output logic                 o_acq_en,
    output logic                 o_acq_start,
    input  logic                 i_frame_done,
    output logic [15:0]          o_frame_cnt,
    output logic                 o_busy
);

    localparam int unsigned AW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int unsigned CW = $clog2(FIN_HOLD + 1);

    localparam logic [15:0] OP_WRITE  = 16'h0001;
    localparam logic [15:0] OP_READ   = 16'h0002;
    localparam logic [15:0] OP_START  = 16'h0003;
    localparam logic [15:0] OP_STOP   = 16'h0004;
    localparam logic [15:0] OP_STATUS = 16'h0005;

    typedef enum logic [1:0] {IDLE, EXEC, FIN_HI, FIN_GAP} state_t;

    state_t                   state;
    logic                     come_s1, come_s2, come_d;
    logic [15:0]              cmd_q;
    logic [31:0]              param_q;
    logic [CW-1:0]            hold_cnt;
    logic [NREG-1:0][15:0]    regs_q;
    logic [15:0]              target_q;

    logic                     edge_c;
    logic [15:0]              addr_c;
    logic [15:0]              data_c;
    logic                     addr_ok_c;
    logic [AW-1:0]            idx_c;
    logic                     exec_c;
    logic                     frame_inc_c;
    logic [15:0]              frame_cnt_nx_c;
    logic                     target_hit_c;
    logic                     start_ok_c;
    logic                     stop_c;
    logic                     wr_c;
    logic                     hold_last_c;
    logic [15:0]              code_c;

    assign edge_c         = come_s2 & ~come_d;
    assign addr_c         = param_q[31:16];
    assign data_c         = param_q[15:0];
    assign addr_ok_c      = (addr_c < 16'(NREG));
    assign idx_c          = addr_c[AW-1:0];
    assign exec_c         = (state == EXEC);
    assign frame_inc_c    = i_frame_done & o_acq_en & (o_frame_cnt != 16'hFFFF);
    assign frame_cnt_nx_c = frame_inc_c ? (o_frame_cnt + 16'd1) : o_frame_cnt;
    assign target_hit_c   = i_frame_done & o_acq_en & (target_q != 16'd0) & (frame_cnt_nx_c == target_q);
    assign start_ok_c     = exec_c & (cmd_q == OP_START) & ~o_acq_en;
    assign stop_c         = exec_c & (cmd_q == OP_STOP);
    assign wr_c           = exec_c & (cmd_q == OP_WRITE) & addr_ok_c;
    assign hold_last_c    = (hold_cnt == CW'(FIN_HOLD - 1));
    assign o_regs         = regs_q;

    // Response code for the command currently in EXEC
    always_comb begin
        code_c = 16'hE0FF;
        case (cmd_q)
            OP_WRITE:  code_c = addr_ok_c ? 16'h0000 : 16'hE001;
            OP_READ:   code_c = addr_ok_c ? regs_q[idx_c] : 16'hE001;
            OP_START:  code_c = o_acq_en ? 16'hE004 : 16'h0000;
            OP_STOP:   code_c = frame_cnt_nx_c;
            OP_STATUS: code_c = {o_acq_en, o_frame_cnt[14:0]};
            default:   code_c = 16'hE0FF;
        endcase
    end

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            come_s1 <= 1'b0;
            come_s2 <= 1'b0;
            come_d  <= 1'b0;
        end else begin
            come_s1 <= i_cmd_come;
            come_s2 <= come_s1;
            come_d  <= come_s2;
        end
    end

    // Command FSM; edges outside IDLE are dropped since only one command is outstanding
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state             <= IDLE;
            cmd_q             <= 16'h0000;
            param_q           <= 32'h0000_0000;
            hold_cnt          <= '0;
            o_cmd_finish      <= 1'b0;
            o_cmd_finish_code <= 16'h0000;
            o_busy            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (edge_c) begin
                        cmd_q   <= i_cmd;
                        param_q <= i_cmd_param;
                        o_busy  <= 1'b1;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    o_cmd_finish_code <= code_c;
                    o_cmd_finish      <= 1'b1;
                    hold_cnt          <= '0;
                    state             <= FIN_HI;
                end
                FIN_HI: begin
                    if (hold_last_c) begin
                        o_cmd_finish <= 1'b0;
                        hold_cnt     <= '0;
                        state        <= FIN_GAP;
                    end else begin
                        hold_cnt <= hold_cnt + CW'(1);
                    end
                end
                FIN_GAP: begin
                    if (hold_last_c) begin
                        o_busy   <= 1'b0;
                        hold_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            regs_q <= '0;
        end else if (wr_c) begin
            regs_q[idx_c] <= data_c;
        end
    end

    // Acquisition control; a START clears the counter, swallowing a coincident frame
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_acq_en    <= 1'b0;
            o_acq_start <= 1'b0;
            o_frame_cnt <= 16'h0000;
            target_q    <= 16'h0000;
        end else begin
            o_acq_start <= 1'b0;
            if (start_ok_c) begin
                target_q    <= data_c;
                o_frame_cnt <= 16'h0000;
                o_acq_en    <= 1'b1;
                o_acq_start <= 1'b1;
            end else begin
                o_frame_cnt <= frame_cnt_nx_c;
                if (target_hit_c || stop_c) begin
                    o_acq_en <= 1'b0;
                end
            end
        end
    end

endmodule
